// File: rtl/masked_subbytes_serial.sv
// Byte-serial sequencer for a masked AES SubBytes: it feeds one external combinational
// masked S-box a byte per cycle and draws fresh output masks from a Galois LFSR.
module masked_subbytes_serial #(
  parameter logic [15:0] LFSR_SEED = 16'hACE1,
  parameter logic [15:0] LFSR_TAPS = 16'hB400
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  input  logic         encrypt,
  input  logic [127:0] state_in,
  input  logic [127:0] mask_in,
  input  logic         seed_load,
  input  logic [15:0]  seed,
  output logic         busy,
  output logic         done,
  output logic [127:0] state_out,
  output logic [127:0] mask_out,
  output logic [7:0]   sbox_a,
  output logic [7:0]   sbox_m,
  output logic [7:0]   sbox_n,
  output logic         sbox_enc,
  input  logic [7:0]   sbox_q
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

  // The all-zero state is the LFSR lock-up point, so it is never allowed in.
  localparam logic [15:0] RESET_LFSR = (LFSR_SEED == 16'h0000) ? 16'h0001 : LFSR_SEED;

  function automatic logic [15:0] lfsr_step8(input logic [15:0] v);
    logic [15:0] r;
    r = v;
    for (int k = 0; k < 8; k++) begin
      r = (r >> 1) ^ (r[0] ? LFSR_TAPS : 16'h0000);
    end
    return r;
  endfunction

  state_e         state_q, state_d;
  logic [3:0]     cnt_q, cnt_d;
  logic           enc_q, enc_d;
  logic [127:0]   data_q, data_d;
  logic [127:0]   in_mask_q, in_mask_d;
  logic [127:0]   state_out_q, state_out_d;
  logic [127:0]   mask_out_q, mask_out_d;
  logic [15:0]    lfsr_q, lfsr_d;
  logic           busy_q, busy_d;
  logic           done_q, done_d;
  logic [6:0]     byte_lsb;

  assign byte_lsb = {cnt_q, 3'b000};

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    enc_d       = enc_q;
    data_d      = data_q;
    in_mask_d   = in_mask_q;
    state_out_d = state_out_q;
    mask_out_d  = mask_out_q;
    lfsr_d      = lfsr_q;
    busy_d      = 1'b0;
    done_d      = 1'b0;
    case (state_q)
      IDLE: begin
        // A reseed in the same cycle as start takes effect before the first byte.
        if (seed_load) begin
          lfsr_d = (seed == 16'h0000) ? 16'h0001 : seed;
        end
        if (start) begin
          state_d   = RUN;
          cnt_d     = 4'd0;
          data_d    = state_in;
          in_mask_d = mask_in;
          enc_d     = encrypt;
          busy_d    = 1'b1;
        end
      end
      RUN: begin
        state_out_d[byte_lsb +: 8] = sbox_q;
        mask_out_d[byte_lsb +: 8]  = lfsr_q[7:0];
        lfsr_d                     = lfsr_step8(lfsr_q);
        if (cnt_q == 4'd15) begin
          state_d = DONE;
          cnt_d   = 4'd0;
          done_d  = 1'b1;
        end else begin
          cnt_d  = cnt_q + 4'd1;
          busy_d = 1'b1;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      cnt_q       <= 4'd0;
      enc_q       <= 1'b0;
      data_q      <= 128'd0;
      in_mask_q   <= 128'd0;
      state_out_q <= 128'd0;
      mask_out_q  <= 128'd0;
      lfsr_q      <= RESET_LFSR;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      enc_q       <= enc_d;
      data_q      <= data_d;
      in_mask_q   <= in_mask_d;
      state_out_q <= state_out_d;
      mask_out_q  <= mask_out_d;
      lfsr_q      <= lfsr_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
    end
  end

  // The S-box bus is forced to zero outside RUN so no stale share leaks out.
  always_comb begin
    sbox_a   = 8'h00;
    sbox_m   = 8'h00;
    sbox_n   = 8'h00;
    sbox_enc = 1'b0;
    if (state_q == RUN) begin
      sbox_a   = data_q[byte_lsb +: 8];
      sbox_m   = in_mask_q[byte_lsb +: 8];
      sbox_n   = lfsr_q[7:0];
      sbox_enc = enc_q;
    end
  end

  assign busy      = busy_q;
  assign done      = done_q;
  assign state_out = state_out_q;
  assign mask_out  = mask_out_q;

endmodule

// File: tb/tb_masked_subbytes_serial.sv
// Scoreboard bench for masked_subbytes_serial: a behavioural masked S-box closes the loop,
// expected results are queued at start and checked by a monitor on every done pulse.
module tb_masked_subbytes_serial;

  logic         clk = 1'b0;
  logic         rst;
  logic         start;
  logic         encrypt;
  logic [127:0] state_in;
  logic [127:0] mask_in;
  logic         seed_load;
  logic [15:0]  seed;
  logic         busy;
  logic         done;
  logic [127:0] state_out;
  logic [127:0] mask_out;
  logic [7:0]   sbox_a;
  logic [7:0]   sbox_m;
  logic [7:0]   sbox_n;
  logic         sbox_enc;
  logic [7:0]   sbox_q;

  always #5 clk = ~clk;

  masked_subbytes_serial dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .encrypt   (encrypt),
    .state_in  (state_in),
    .mask_in   (mask_in),
    .seed_load (seed_load),
    .seed      (seed),
    .busy      (busy),
    .done      (done),
    .state_out (state_out),
    .mask_out  (mask_out),
    .sbox_a    (sbox_a),
    .sbox_m    (sbox_m),
    .sbox_n    (sbox_n),
    .sbox_enc  (sbox_enc),
    .sbox_q    (sbox_q)
  );

  logic [7:0] sbox_t [256];
  logic [7:0] inv_t  [256];

  // Behavioural masked S-box: Q = S(A ^ M) ^ N.
  assign sbox_q = sbox_enc ? (sbox_t[sbox_a ^ sbox_m] ^ sbox_n)
                           : (inv_t[sbox_a ^ sbox_m] ^ sbox_n);

  typedef struct {
    logic [127:0] plain;
    logic [127:0] mask;
  } exp_t;

  exp_t        sb_q[$];
  int          tests_run  = 0;
  int          fail_count = 0;
  logic [15:0] model_lfsr;

  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p, x, y;
    p = 8'h00;
    x = a;
    y = b;
    for (int i = 0; i < 8; i++) begin
      if (y[0]) p = p ^ x;
      x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1B : 8'h00);
      y = y >> 1;
    end
    return p;
  endfunction

  function automatic logic [7:0] ginv(input logic [7:0] a);
    logic [7:0] r;
    r = 8'h00;
    for (int c = 1; c < 256; c++) begin
      if (gmul(a, 8'(c)) == 8'h01) r = 8'(c);
    end
    return r;
  endfunction

  function automatic logic [7:0] affine(input logic [7:0] x);
    logic [7:0] b;
    for (int i = 0; i < 8; i++) begin
      b[i] = x[i] ^ x[(i+4)%8] ^ x[(i+5)%8] ^ x[(i+6)%8] ^ x[(i+7)%8];
    end
    return b ^ 8'h63;
  endfunction

  function automatic logic [7:0] inv_affine(input logic [7:0] x);
    logic [7:0] b;
    for (int i = 0; i < 8; i++) begin
      b[i] = x[(i+2)%8] ^ x[(i+5)%8] ^ x[(i+7)%8];
    end
    return b ^ 8'h05;
  endfunction

  function automatic logic [15:0] model_step8(input logic [15:0] v);
    logic [15:0] r;
    r = v;
    for (int k = 0; k < 8; k++) begin
      if (r[0]) r = (r >> 1) ^ 16'hB400;
      else      r = r >> 1;
    end
    return r;
  endfunction

  task automatic checkOutput(input string name, input logic [127:0] actual,
                             input logic [127:0] expected);
    tests_run++;
    if (actual !== expected) begin
      fail_count++;
      $display("[TB] FAIL %s: got %h expected %h", name, actual, expected);
    end
  endtask

  // Monitor: pops one expectation per done pulse and polices the idle S-box bus.
  task automatic monitor();
    exp_t e;
    forever begin
      @(negedge clk);
      if (!rst) begin
        if (done === 1'b1) begin
          if (sb_q.size() == 0) begin
            checkOutput("unexpected_done", 128'd1, 128'd0);
          end else begin
            e = sb_q.pop_front();
            checkOutput("mask_out", mask_out, e.mask);
            checkOutput("unmasked_out", state_out ^ mask_out, e.plain);
          end
        end
        if (busy === 1'b0) begin
          checkOutput("sbox_bus_idle", {103'd0, sbox_enc, sbox_a, sbox_m, sbox_n}, 128'd0);
        end
      end
    end
  endtask

  task automatic applyReset();
    @(negedge clk);
    rst        = 1'b1;
    model_lfsr = 16'hACE1;
    sb_q.delete();
    repeat (2) @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic loadSeed(input logic [15:0] sd);
    @(negedge clk);
    seed_load  = 1'b1;
    seed       = sd;
    model_lfsr = (sd == 16'h0000) ? 16'h0001 : sd;
    @(negedge clk);
    seed_load = 1'b0;
  endtask

  // One full run: queue the expectation, pulse start, optionally poke start and
  // seed_load mid-run, and check busy/done timing.
  task automatic applyStimulus(input logic enc, input logic [127:0] st,
                               input logic [127:0] mk, input logic do_seed,
                               input logic [15:0] sd, input logic disturb);
    exp_t e;
    int   lat;
    logic [7:0] x;
    if (do_seed) model_lfsr = (sd == 16'h0000) ? 16'h0001 : sd;
    for (int i = 0; i < 16; i++) begin
      x = st[8*i +: 8] ^ mk[8*i +: 8];
      e.mask[8*i +: 8]  = model_lfsr[7:0];
      e.plain[8*i +: 8] = enc ? sbox_t[x] : inv_t[x];
      model_lfsr = model_step8(model_lfsr);
    end
    sb_q.push_back(e);
    @(negedge clk);
    state_in  = st;
    mask_in   = mk;
    encrypt   = enc;
    start     = 1'b1;
    seed_load = do_seed;
    seed      = sd;
    @(posedge clk);
    lat = 0;
    for (int n = 1; n <= 40; n++) begin
      @(negedge clk);
      start     = disturb && (n == 5 || n == 16);
      seed_load = disturb && (n == 5);
      seed      = 16'hFFFF;
      if (n == 1) begin
        checkOutput("busy_first_cycle", {127'd0, busy}, 128'd1);
        state_in = ~st;
        mask_in  = ~mk;
        encrypt  = ~enc;
      end
      if (done === 1'b1) begin
        lat = n;
        checkOutput("busy_at_done", {127'd0, busy}, 128'd0);
        break;
      end
    end
    checkOutput("done_latency", 128'(lat), 128'd17);
    start     = 1'b0;
    seed_load = 1'b0;
  endtask

  task automatic midRunReset();
    logic saw_done;
    @(negedge clk);
    state_in = {16{8'hA5}};
    mask_in  = {16{8'h3C}};
    encrypt  = 1'b1;
    start    = 1'b1;
    @(posedge clk);
    for (int n = 1; n <= 8; n++) begin
      @(negedge clk);
      start = 1'b0;
    end
    rst = 1'b1;
    @(negedge clk);
    checkOutput("rst_busy", {127'd0, busy}, 128'd0);
    checkOutput("rst_done", {127'd0, done}, 128'd0);
    checkOutput("rst_state_out", state_out, 128'd0);
    checkOutput("rst_mask_out", mask_out, 128'd0);
    rst        = 1'b0;
    model_lfsr = 16'hACE1;
    sb_q.delete();
    saw_done = 1'b0;
    repeat (25) begin
      @(negedge clk);
      if (done === 1'b1) saw_done = 1'b1;
    end
    checkOutput("no_done_after_rst", {127'd0, saw_done}, 128'd0);
  endtask

  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: got timeout expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    logic [127:0] st;
    logic [127:0] mk;
    for (int v = 0; v < 256; v++) begin
      sbox_t[v] = affine(ginv(v[7:0]));
      inv_t[v]  = ginv(inv_affine(v[7:0]));
    end
    rst       = 1'b1;
    start     = 1'b0;
    encrypt   = 1'b0;
    state_in  = 128'd0;
    mask_in   = 128'd0;
    seed_load = 1'b0;
    seed      = 16'h0000;
    fork
      monitor();
    join_none

    applyReset();
    checkOutput("reset_busy", {127'd0, busy}, 128'd0);
    checkOutput("reset_done", {127'd0, done}, 128'd0);
    checkOutput("reset_state_out", state_out, 128'd0);
    checkOutput("reset_mask_out", mask_out, 128'd0);

    // Zero state forward: every unmasked byte is S(0) = 63.
    applyStimulus(1'b1, 128'd0, 128'd0, 1'b0, 16'h0000, 1'b0);
    checkOutput("t1_unmasked", state_out ^ mask_out, {16{8'h63}});
    checkOutput("t1_mask_b0", {120'd0, mask_out[7:0]}, 128'hE1);
    checkOutput("t1_mask_b1", {120'd0, mask_out[15:8]}, 128'hC4);

    applyStimulus(1'b0, {16{8'h63}}, 128'd0, 1'b0, 16'h0000, 1'b0);
    checkOutput("t2_unmasked", state_out ^ mask_out, 128'd0);
    for (int i = 0; i < 16; i++) st[8*i +: 8] = 8'(i);
    applyStimulus(1'b0, st, {16{8'h5A}}, 1'b0, 16'h0000, 1'b0);

    loadSeed(16'h0000);
    applyStimulus(1'b1, {16{8'h11}}, {16{8'h22}}, 1'b0, 16'h0000, 1'b0);
    checkOutput("t3_mask_b0", {120'd0, mask_out[7:0]}, 128'h01);
    checkOutput("t3_mask_b1", {120'd0, mask_out[15:8]}, 128'h68);
    applyStimulus(1'b1, {16{8'h11}}, {16{8'h22}}, 1'b1, 16'h1234, 1'b0);
    checkOutput("t3_seed_b0", {120'd0, mask_out[7:0]}, 128'h34);

    loadSeed(16'h00FF);
    applyStimulus(1'b1, st, {16{8'hC3}}, 1'b0, 16'h0000, 1'b1);
    repeat (5) @(negedge clk);

    midRunReset();
    applyStimulus(1'b1, 128'd0, 128'd0, 1'b0, 16'h0000, 1'b0);
    checkOutput("t5_mask_b0", {120'd0, mask_out[7:0]}, 128'hE1);

    for (int r = 0; r < 1000; r++) begin
      st = {$urandom, $urandom, $urandom, $urandom};
      mk = {$urandom, $urandom, $urandom, $urandom};
      applyStimulus(1'($urandom_range(0, 1)), st, mk, 1'b0, 16'h0000, 1'b0);
    end
    repeat (4) @(negedge clk);
    checkOutput("scoreboard_drained", 128'(sb_q.size()), 128'd0);

    $display("[TB] %0d tests run, %0d failed", tests_run, fail_count);
    $finish;
  end

endmodule

// File: doc/masked_subbytes_serial.md
Name: masked_subbytes_serial

Overview:
Sequencer that drives one combinational masked S-box (sbox_masked_canright) over a full 128-bit masked AES state, one byte per cycle. It supplies the per-byte input mask and a fresh 8-bit output mask drawn from an internal LFSR, then collects the masked results and output masks into 128-bit registers. It sits between the round-state register and the masked ShiftRows/MixColumns datapath.

Parameters:
LFSR_SEED, 16'hACE1, LFSR value after reset; a value of 0 is replaced by 16'h0001.
LFSR_TAPS, 16'hB400, Galois feedback mask (x^16+x^14+x^13+x^11+1).

Ports:
clk  in  1  clock; all state updates on the rising edge.
rst  in  1  synchronous, active-high reset.
start  in  1  one-cycle request; sampled only in IDLE.
encrypt  in  1  1 = forward S-box, 0 = inverse; latched on start.
state_in  in  128  masked state; byte i = bits [8i+7:8i].
mask_in  in  128  per-byte input masks M for state_in.
seed_load  in  1  load LFSR from seed; honoured in IDLE only.
seed  in  16  LFSR reseed value; 0 is replaced by 16'h0001.
busy  out  1  high in RUN.
done  out  1  one-cycle pulse; outputs are valid.
state_out  out  128  masked SubBytes result.
mask_out  out  128  per-byte output masks N for state_out.
sbox_a  out  8  to S-box A (masked byte).
sbox_m  out  8  to S-box M.
sbox_n  out  8  to S-box N.
sbox_enc  out  1  to S-box encrypt.
sbox_q  in  8  from S-box Q (combinational, same cycle).

Behaviour:
- FSM states: IDLE, RUN, DONE.
  - IDLE -> RUN on start. Latch state_in, mask_in and encrypt. Set cnt = 0.
  - RUN: cnt counts 0..15. After the cnt = 15 cycle, go to DONE.
  - DONE -> IDLE unconditionally. done = 1 for exactly this cycle.
- RUN, each cycle:
  - sbox_a = latched byte[cnt]; sbox_m = mask byte[cnt]; sbox_n = lfsr[7:0]; sbox_enc = latched encrypt.
  - At the clock edge: state_out byte[cnt] <= sbox_q; mask_out byte[cnt] <= lfsr[7:0].
  - At the same edge the LFSR advances 8 Galois steps, unrolled: per step lfsr = (lfsr >> 1) ^ (lfsr[0] ? LFSR_TAPS : 0).
- Latency:
  - start sampled at edge t: busy = 1 during cycles t+1..t+16.
  - done = 1 in cycle t+17; busy = 0 in that cycle.
  - A new start is accepted at edge t+18.
- Outside RUN: sbox_a/m/n = 0 and sbox_enc = 0, so no unmasked or stale data is driven.
- state_out and mask_out hold their values from DONE until the next run overwrites them byte by byte. They are valid only when done = 1.
- start while busy or in DONE: ignored, no queueing.
- seed_load:
  - Honoured in IDLE only; ignored in RUN/DONE.
  - If seed_load and start arrive in the same IDLE cycle, the seed loads first and the run uses the new seed.
  - A zero seed is replaced by 16'h0001. The LFSR never reaches 0.
- The LFSR advances only in RUN.
- rst (any state, including mid-RUN):
  - FSM -> IDLE, cnt = 0, busy = 0, done = 0.
  - state_out, mask_out and the internal latches = 0.
  - lfsr = LFSR_SEED, or 16'h0001 if LFSR_SEED is 0.
  - An in-flight operation is discarded; no done pulse follows.
- Correctness invariant, per byte i: state_out_i ^ mask_out_i = S(state_in_i ^ mask_in_i), where S is the forward S-box if encrypt = 1 and the inverse S-box if encrypt = 0.

Test Plan:
1. rst; state_in = 0, mask_in = 0, encrypt = 1, start → done at start+17; every byte of state_out ^ mask_out = 8'h63; mask_out bytes equal the bench LFSR model sequence from 16'hACE1.
2. encrypt = 0, state_in = all 8'h63, mask_in = 0 → every unmasked byte = 8'h00; with state_in bytes 0x00..0x0F and mask_in = all 8'h5A, the unmasked result matches the inverse-S-box model per byte.
3. seed_load with seed = 0, then start → mask_out byte0 = 8'h01 (LFSR forced to 16'h0001); seed = 16'h1234 on a second run → bench-predicted mask_out.
4. Assert start during RUN (cycles 5 and 16) → ignored; single done pulse; results identical to the undisturbed run.
5. Assert rst at cnt = 7 → next cycle busy = 0, outputs = 0, no done; a fresh start yields masks from LFSR_SEED again.
6. 1000 random state_in/mask_in/encrypt runs checked against the invariant; check sbox_a/m/n = 0 whenever busy = 0.
